// File: rtl/cp0_regfile_pkg.sv
// cp0_regfile_pkg: exception type codes, CP0 register addresses and Status/Cause bit positions
package cp0_regfile_pkg;
  localparam logic [31:0] EXC_TYPE_NOEXC = 32'h0000_0000;
  localparam logic [31:0] EXC_TYPE_INT   = 32'h0000_0001;
  localparam logic [31:0] EXC_TYPE_ADEL  = 32'h0000_0004;
  localparam logic [31:0] EXC_TYPE_ADES  = 32'h0000_0005;
  localparam logic [31:0] EXC_TYPE_SYS   = 32'h0000_0008;
  localparam logic [31:0] EXC_TYPE_BP    = 32'h0000_0009;
  localparam logic [31:0] EXC_TYPE_RI    = 32'h0000_000a;
  localparam logic [31:0] EXC_TYPE_OV    = 32'h0000_000c;
  localparam logic [31:0] EXC_TYPE_ERET  = 32'h0000_000e;
  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;
  localparam logic [4:0] CP0_REG_PRID     = 5'd15;
  localparam logic [31:0] PRID_VALUE = 32'h0000_4220;
  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int STATUS_BEV = 22;
  localparam int CAUSE_TI   = 30;
  localparam int CAUSE_BD   = 31;
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare pair with half-rate tick and timer interrupt (enabled by CP0_TIMER_INT_EN)
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);
  logic tick;
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      compare <= '0;
      tick <= 1'b0;
    end else begin
      tick <= count_we ? 1'b0 : ~tick;
      count <= count_we ? wdata : count + {31'b0, tick};
      if (compare_we) compare <= wdata;
    end
  end
`ifdef CP0_TIMER_INT_EN
  logic pending;
  logic match;
  assign match = (count == compare) && (compare != '0);
  // the match is visible immediately; pending keeps it until Compare is rewritten
  always_ff @(posedge clk) begin
    if (rst) pending <= 1'b0;
    else pending <= !compare_we && (pending || match);
  end
  assign timer_int = pending || match;
`else
  assign timer_int = 1'b0;
`endif
endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS CP0 subset (BadVAddr, Count, Compare, Status, Cause, EPC, PRId); timer IRQ via CP0_TIMER_INT_EN
module cp0_regfile
  import cp0_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] wdata_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] exception_type_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] badvaddr_i,
  input  logic        in_delayslot_i,
  output logic [31:0] rdata_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);
  logic eret, exc, wr;
  logic [7:0] im;
  logic exl, ie, bd;
  logic [4:0] exc_code;
  logic [5:0] ip_hw;
  logic [1:0] ip_sw;
  assign eret = exception_type_i == EXC_TYPE_ERET;
  assign exc = (exception_type_i != EXC_TYPE_NOEXC) && !eret;
  assign wr = we_i && !exc && !eret;
  cp0_timer u_timer (
    .clk(clk),
    .rst(rst),
    .count_we(wr && waddr_i == CP0_REG_COUNT),
    .compare_we(wr && waddr_i == CP0_REG_COMPARE),
    .wdata(wdata_i),
    .count(count_o),
    .compare(compare_o),
    .timer_int(timer_int_o)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      {im, exl, ie, bd} <= '0;
      exc_code <= '0;
      ip_hw <= '0;
      ip_sw <= '0;
      epc_o <= '0;
      badvaddr_o <= '0;
    end else begin
      ip_hw <= {int_i[5] | timer_int_o, int_i[4:0]};
      if (exc) begin
        exl <= 1'b1;
        exc_code <= exception_type_i == EXC_TYPE_INT ? 5'd0 : exception_type_i[4:0];
        // a nested exception keeps the EPC/BD of the original one
        if (!exl) begin
          epc_o <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
          bd <= in_delayslot_i;
        end
        if (exception_type_i == EXC_TYPE_ADEL || exception_type_i == EXC_TYPE_ADES) badvaddr_o <= badvaddr_i;
      end else if (eret) begin
        exl <= 1'b0;
      end else if (wr) begin
        if (waddr_i == CP0_REG_STATUS) {im, exl, ie} <= {wdata_i[15:8], wdata_i[STATUS_EXL], wdata_i[STATUS_IE]};
        if (waddr_i == CP0_REG_CAUSE) ip_sw <= wdata_i[9:8];
        if (waddr_i == CP0_REG_EPC) epc_o <= wdata_i;
      end
    end
  end
  always_comb begin
    status_o = '0;
    status_o[STATUS_BEV] = 1'b1;
    status_o[15:8] = im;
    status_o[STATUS_EXL] = exl;
    status_o[STATUS_IE] = ie;
    cause_o = '0;
    cause_o[CAUSE_BD] = bd;
    cause_o[CAUSE_TI] = timer_int_o;
    cause_o[15:8] = {ip_hw, ip_sw};
    cause_o[6:2] = exc_code;
  end
  assign rdata_o = raddr_i == CP0_REG_BADVADDR ? badvaddr_o :
                   raddr_i == CP0_REG_COUNT    ? count_o    :
                   raddr_i == CP0_REG_COMPARE  ? compare_o  :
                   raddr_i == CP0_REG_STATUS   ? status_o   :
                   raddr_i == CP0_REG_CAUSE    ? cause_o    :
                   raddr_i == CP0_REG_EPC      ? epc_o      :
                   raddr_i == CP0_REG_PRID     ? PRID_VALUE : '0;
endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: directed scenarios plus randomized traffic against a word-level CP0 reference model
module tb_cp0_regfile;
  logic clk = 1'b0, rst = 1'b1, we_i = 1'b0, in_delayslot_i = 1'b0;
  logic [4:0] waddr_i = '0, raddr_i = '0;
  logic [31:0] wdata_i = '0, exception_type_i = '0, pc_i = '0, badvaddr_i = '0;
  logic [5:0] int_i = '0;
  logic [31:0] rdata_o, status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o;
  logic timer_int_o;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  cp0_regfile dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i), .wdata_i(wdata_i),
    .int_i(int_i), .exception_type_i(exception_type_i), .pc_i(pc_i), .badvaddr_i(badvaddr_i),
    .in_delayslot_i(in_delayslot_i), .rdata_o(rdata_o), .status_o(status_o), .cause_o(cause_o),
    .epc_o(epc_o), .badvaddr_o(badvaddr_o), .count_o(count_o), .compare_o(compare_o),
    .timer_int_o(timer_int_o)
  );
  logic [31:0] m_status, m_cause, m_epc, m_bad, m_count, m_compare;
  logic m_tick, m_pend;
  function automatic logic m_timer();
`ifdef CP0_TIMER_INT_EN
    return m_pend || (m_count == m_compare && m_compare != 32'd0);
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic [31:0] m_cause_full();
    return m_cause | (m_timer() ? 32'h4000_0000 : 32'h0);
  endfunction
  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8: return m_bad;
      5'd9: return m_count;
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause_full();
      5'd14: return m_epc;
      5'd15: return 32'h0000_4220;
      default: return 32'h0;
    endcase
  endfunction
  task automatic model_reset();
    m_status = 32'h0040_0000;
    {m_cause, m_epc, m_bad, m_count, m_compare} = '0;
    m_tick = 1'b0;
    m_pend = 1'b0;
  endtask
  task automatic model_step();
    logic t, hit, is_eret, is_exc, w;
    t = m_timer();
    hit = m_count == m_compare && m_compare != 32'd0;
    is_eret = exception_type_i == 32'he;
    is_exc = exception_type_i != 32'h0 && !is_eret;
    w = we_i && !is_exc && !is_eret;
    m_cause[15:10] = {int_i[5] | t, int_i[4:0]};
    if (is_exc) begin
      if (!m_status[1]) begin
        m_epc = in_delayslot_i ? pc_i - 32'd4 : pc_i;
        m_cause[31] = in_delayslot_i;
      end
      m_status[1] = 1'b1;
      m_cause[6:2] = exception_type_i == 32'h1 ? 5'd0 : exception_type_i[4:0];
      if (exception_type_i == 32'h4 || exception_type_i == 32'h5) m_bad = badvaddr_i;
    end else if (is_eret) begin
      m_status[1] = 1'b0;
    end else if (w) begin
      if (waddr_i == 5'd12) m_status = (wdata_i & 32'h0000_ff03) | 32'h0040_0000;
      if (waddr_i == 5'd13) m_cause = (m_cause & ~32'h300) | (wdata_i & 32'h300);
      if (waddr_i == 5'd14) m_epc = wdata_i;
    end
    m_pend = (w && waddr_i == 5'd11) ? 1'b0 : (m_pend || hit);
    if (w && waddr_i == 5'd11) m_compare = wdata_i;
    if (w && waddr_i == 5'd9) begin
      m_count = wdata_i;
      m_tick = 1'b0;
    end else begin
      m_count = m_count + (m_tick ? 32'd1 : 32'd0);
      m_tick = !m_tick;
    end
  endtask
  task automatic clock_cycle();
    if (rst) model_reset();
    else model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    we_i = 1'b0;
    exception_type_i = 32'h0;
    in_delayslot_i = 1'b0;
    int_i = '0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    we_i = 1'b1;
    waddr_i = 5'd12;
    wdata_i = 32'hffff_ffff;
    exception_type_i = 32'h4;
    int_i = 6'h3f;
    repeat (3) clock_cycle();
    n_checks++; if (status_o !== 32'h0040_0000) begin n_fail++; $display("FAIL reset_status got=%h exp=%h", status_o, 32'h0040_0000); end
    n_checks++; if (cause_o !== 32'h0) begin n_fail++; $display("FAIL reset_cause got=%h exp=0", cause_o); end
    n_checks++; if (epc_o !== 32'h0 || badvaddr_o !== 32'h0) begin n_fail++; $display("FAIL reset_epc_bad got=%h/%h exp=0/0", epc_o, badvaddr_o); end
    n_checks++; if (count_o !== 32'h0 || compare_o !== 32'h0 || timer_int_o !== 1'b0) begin n_fail++; $display("FAIL reset_timer got=%h/%h/%b exp=0/0/0", count_o, compare_o, timer_int_o); end
    raddr_i = 5'd12; #1;
    n_checks++; if (rdata_o !== 32'h0040_0000) begin n_fail++; $display("FAIL reset_read12 got=%h exp=%h", rdata_o, 32'h0040_0000); end
    raddr_i = 5'd15; #1;
    n_checks++; if (rdata_o !== 32'h0000_4220) begin n_fail++; $display("FAIL reset_read15 got=%h exp=%h", rdata_o, 32'h0000_4220); end
    rst = 1'b0;
    idle();
  endtask
  task automatic test_timer();
    logic exp_t;
`ifdef CP0_TIMER_INT_EN
    exp_t = 1'b1;
`else
    exp_t = 1'b0;
`endif
    we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'd5; clock_cycle();
    waddr_i = 5'd9; wdata_i = 32'd0; clock_cycle();
    idle();
    repeat (10) clock_cycle();
    raddr_i = 5'd9; #1;
    n_checks++; if (count_o !== 32'd5 || rdata_o !== 32'd5) begin n_fail++; $display("FAIL timer_count got=%0d/%0d exp=5", count_o, rdata_o); end
    n_checks++; if (timer_int_o !== exp_t) begin n_fail++; $display("FAIL timer_int got=%b exp=%b", timer_int_o, exp_t); end
    n_checks++; if (cause_o[30] !== exp_t) begin n_fail++; $display("FAIL timer_cause_ti got=%b exp=%b", cause_o[30], exp_t); end
    clock_cycle();
    n_checks++; if (cause_o[15] !== exp_t) begin n_fail++; $display("FAIL timer_cause_ip7 got=%b exp=%b", cause_o[15], exp_t); end
    we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'd100; clock_cycle();
    idle();
    n_checks++; if (timer_int_o !== 1'b0 || compare_o !== 32'd100) begin n_fail++; $display("FAIL timer_clear got=%b/%0d exp=0/100", timer_int_o, compare_o); end
  endtask
  task automatic test_exceptions();
    exception_type_i = 32'h4; pc_i = 32'hbfc0_0100; badvaddr_i = 32'h1003; in_delayslot_i = 1'b1;
    clock_cycle();
    idle();
    n_checks++; if (epc_o !== 32'hbfc0_00fc) begin n_fail++; $display("FAIL adel_epc got=%h exp=%h", epc_o, 32'hbfc0_00fc); end
    n_checks++; if (badvaddr_o !== 32'h1003) begin n_fail++; $display("FAIL adel_badvaddr got=%h exp=%h", badvaddr_o, 32'h1003); end
    n_checks++; if (cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'h04 || status_o[1] !== 1'b1) begin n_fail++; $display("FAIL adel_flags got=bd%b code%h exl%b exp=bd1 code04 exl1", cause_o[31], cause_o[6:2], status_o[1]); end
    exception_type_i = 32'h8; pc_i = 32'h80; badvaddr_i = 32'hdead;
    clock_cycle();
    idle();
    n_checks++; if (epc_o !== 32'hbfc0_00fc || cause_o[6:2] !== 5'h08 || cause_o[31] !== 1'b1) begin n_fail++; $display("FAIL nested_sys got=epc%h code%h bd%b exp=epc%h code08 bd1", epc_o, cause_o[6:2], cause_o[31], 32'hbfc0_00fc); end
    n_checks++; if (badvaddr_o !== 32'h1003) begin n_fail++; $display("FAIL nested_badvaddr got=%h exp=%h", badvaddr_o, 32'h1003); end
    exception_type_i = 32'he; clock_cycle(); idle();
    n_checks++; if (status_o !== 32'h0040_0000) begin n_fail++; $display("FAIL eret_status got=%h exp=%h", status_o, 32'h0040_0000); end
    exception_type_i = 32'hc; pc_i = 32'h200; we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'hffff_ffff;
    clock_cycle();
    idle();
    n_checks++; if (status_o !== 32'h0040_0002 || cause_o[6:2] !== 5'h0c) begin n_fail++; $display("FAIL exc_vs_mtc0 got=%h code%h exp=%h code0c", status_o, cause_o[6:2], 32'h0040_0002); end
    n_checks++; if (epc_o !== 32'h200 || cause_o[31] !== 1'b0) begin n_fail++; $display("FAIL ov_epc got=%h bd%b exp=00000200 bd0", epc_o, cause_o[31]); end
    exception_type_i = 32'he; clock_cycle(); idle();
    exception_type_i = 32'h1; pc_i = 32'h300; clock_cycle(); idle();
    n_checks++; if (cause_o[6:2] !== 5'h0 || epc_o !== 32'h300) begin n_fail++; $display("FAIL int_code got=%h epc%h exp=00 epc00000300", cause_o[6:2], epc_o); end
    exception_type_i = 32'he; clock_cycle(); idle();
  endtask
  task automatic test_masks();
    int_i = 6'b000100; clock_cycle();
    n_checks++; if (cause_o[12] !== 1'b1 || cause_o[15:10] !== 6'b000100) begin n_fail++; $display("FAIL cause_hwint got=%b exp=000100", cause_o[15:10]); end
    we_i = 1'b1; waddr_i = 5'd13; wdata_i = 32'hffff_ffff; clock_cycle();
    n_checks++; if (cause_o !== m_cause_full() || cause_o[9:8] !== 2'b11) begin n_fail++; $display("FAIL cause_write got=%h exp=%h", cause_o, m_cause_full()); end
    waddr_i = 5'd12; clock_cycle();
    n_checks++; if (status_o !== 32'h0040_ff03) begin n_fail++; $display("FAIL status_mask got=%h exp=%h", status_o, 32'h0040_ff03); end
    waddr_i = 5'd8; wdata_i = 32'h5555_5555; clock_cycle();
    waddr_i = 5'd15; clock_cycle();
    raddr_i = 5'd15; #1;
    n_checks++; if (badvaddr_o !== 32'h1003 || rdata_o !== 32'h0000_4220) begin n_fail++; $display("FAIL readonly got=%h/%h exp=%h/%h", badvaddr_o, rdata_o, 32'h1003, 32'h4220); end
    waddr_i = 5'd12; wdata_i = 32'h0; clock_cycle();
    waddr_i = 5'd13; clock_cycle();
    idle();
    raddr_i = 5'd5; #1;
    n_checks++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL unimpl_read got=%h exp=0", rdata_o); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] old_epc;
    old_epc = m_epc;
    we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h1234_5678; raddr_i = 5'd14; #1;
    n_checks++; if (rdata_o !== old_epc) begin n_fail++; $display("FAIL no_bypass got=%h exp=%h", rdata_o, old_epc); end
    clock_cycle();
    n_checks++; if (rdata_o !== 32'h1234_5678) begin n_fail++; $display("FAIL epc_write got=%h exp=%h", rdata_o, 32'h1234_5678); end
    waddr_i = 5'd9; wdata_i = 32'h10; clock_cycle();
    wdata_i = 32'hffff_ffff; clock_cycle();
    idle();
    n_checks++; if (count_o !== 32'hffff_ffff) begin n_fail++; $display("FAIL count_b2b got=%h exp=ffffffff", count_o); end
    clock_cycle(); clock_cycle();
    n_checks++; if (count_o !== 32'h0) begin n_fail++; $display("FAIL count_wrap got=%h exp=0", count_o); end
  endtask
  logic [4:0] addrs [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd5};
  logic [31:0] excs [9] = '{32'h0, 32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc, 32'he};
  string names [8] = '{"status", "cause", "epc", "badvaddr", "count", "compare", "timer_int", "rdata"};
  task automatic test_random();
    logic [31:0] got [8];
    logic [31:0] exp [8];
    for (int i = 0; i < 500; i++) begin
      rst = $urandom_range(0, 99) == 0;
      we_i = $urandom_range(0, 2) == 0;
      waddr_i = addrs[$urandom_range(0, 7)];
      wdata_i = $urandom;
      if (waddr_i == 5'd11 && $urandom_range(0, 1) == 1) wdata_i = m_count + 32'($urandom_range(0, 3));
      raddr_i = $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : addrs[$urandom_range(0, 7)];
      int_i = $urandom_range(0, 3) == 0 ? 6'($urandom) : 6'h0;
      exception_type_i = $urandom_range(0, 49) == 0 ? $urandom : ($urandom_range(0, 4) == 0 ? excs[$urandom_range(0, 8)] : 32'h0);
      pc_i = $urandom & 32'hffff_fffc;
      badvaddr_i = $urandom;
      in_delayslot_i = 1'($urandom);
      clock_cycle();
      got = '{status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o, {31'b0, timer_int_o}, rdata_o};
      exp = '{m_status, m_cause_full(), m_epc, m_bad, m_count, m_compare, {31'b0, m_timer()}, m_read(raddr_i)};
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if (got[k] !== exp[k]) begin
          n_fail++;
          $display("FAIL rand_%s cycle=%0d got=%h exp=%h", names[k], i, got[k], exp[k]);
        end
      end
    end
    rst = 1'b0;
    idle();
  endtask
  initial begin
    model_reset();
    test_reset();
    test_timer();
    test_exceptions();
    test_masks();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
